// File: rtl/hbmc_wdata_sequencer.sv
// rtl/hbmc_wdata_sequencer.sv - drains one write burst from the write-data FIFO into the DDR write stream
// A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency; on abort the rest of the burst is popped and dropped.
module hbmc_wdata_sequencer #(
    parameter int LEN_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 cmd_start,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 cmd_abort,
    output logic                 cmd_busy,
    output logic                 cmd_done,
    output logic                 cmd_aborted,
    input  logic [15:0]          fifo_rd_dout,
    input  logic [1:0]           fifo_rd_strb,
    output logic                 fifo_rd_ena,
    input  logic                 fifo_rd_empty,
    output logic [15:0]          wr_data,
    output logic [1:0]           wr_strb,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic                 wr_last,
    output logic                 wr_stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] popped_q, popped_d;
    logic [LEN_WIDTH-1:0] delivered_q, delivered_d;
    logic                 inflight_q;
    logic                 aborted_q, aborted_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [1:0][17:0]     buf_q, buf_d;

    logic                 hs;
    logic                 more;
    logic [1:0]           cnt_p;
    logic                 fits;
    logic                 rd_ena;

    assign wr_valid    = (state_q == S_RUN) && (cnt_q != 2'd0);
    assign hs          = wr_valid & wr_ready;
    assign more        = popped_q < len_q;
    // Occupancy after this cycle's handshake, plus the word already on its way from the FIFO.
    assign cnt_p       = cnt_q - {1'b0, hs};
    assign fits        = ({1'b0, cnt_p} + {2'b00, inflight_q} + 3'd1) <= 3'd2;

    assign wr_data     = wr_valid ? buf_q[0][15:0] : 16'h0000;
    assign wr_strb     = wr_valid ? buf_q[0][17:16] : 2'b00;
    assign wr_last     = wr_valid && (delivered_q == len_q - LEN_WIDTH'(1));
    assign wr_stall    = (state_q == S_RUN) && (cnt_q == 2'd0) && (delivered_q != len_q);
    assign cmd_busy    = (state_q != S_IDLE);
    assign cmd_done    = (state_q == S_DONE);
    assign cmd_aborted = (state_q == S_DONE) && aborted_q;
    assign fifo_rd_ena = rd_ena;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        popped_d    = popped_q;
        delivered_d = delivered_q;
        aborted_d   = aborted_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        rd_ena      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_start && (cmd_len != '0)) begin
                    // The first pop is issued with the start so the first word is valid two cycles later.
                    state_d     = S_RUN;
                    len_d       = cmd_len;
                    popped_d    = '0;
                    delivered_d = '0;
                    aborted_d   = 1'b0;
                    cnt_d       = 2'd0;
                    rd_ena      = ~fifo_rd_empty;
                end
            end
            S_RUN: begin
                rd_ena = ~fifo_rd_empty & more & fits;
                if (hs) begin
                    buf_d[0]    = buf_q[1];
                    delivered_d = delivered_q + LEN_WIDTH'(1);
                end
                cnt_d = cnt_p;
                if (inflight_q) begin
                    buf_d[cnt_p[0]] = {fifo_rd_strb, fifo_rd_dout};
                    cnt_d           = cnt_p + 2'd1;
                end
                if (hs && wr_last) begin
                    state_d = S_DONE;
                end else if (cmd_abort) begin
                    state_d   = S_FLUSH;
                    aborted_d = 1'b1;
                    cnt_d     = 2'd0;
                end
            end
            S_FLUSH: begin
                rd_ena = ~fifo_rd_empty & more;
                if (!more && !inflight_q) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rd_ena) begin
            popped_d = popped_d + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            popped_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
            aborted_q   <= 1'b0;
            cnt_q       <= 2'd0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            popped_q    <= popped_d;
            delivered_q <= delivered_d;
            inflight_q  <= rd_ena;
            aborted_q   <= aborted_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
        end
    end

endmodule

// File: tb/tb_hbmc_wdata_sequencer.sv
// tb/tb_hbmc_wdata_sequencer.sv - scoreboard bench for hbmc_wdata_sequencer
// Bursts take consecutive words of the pushed stream; a negedge monitor checks every handshake and done pulse.
module tb_hbmc_wdata_sequencer;

    typedef logic [17:0] word_t;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        cmd_start = 1'b0;
    logic [8:0]  cmd_len = '0;
    logic        cmd_abort = 1'b0;
    logic        cmd_busy, cmd_done, cmd_aborted;
    logic [15:0] fifo_rd_dout;
    logic [1:0]  fifo_rd_strb;
    logic        fifo_rd_ena;
    logic        fifo_rd_empty;
    logic [15:0] wr_data;
    logic [1:0]  wr_strb;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic        wr_last, wr_stall;

    hbmc_wdata_sequencer #(.LEN_WIDTH(9)) dut (
        .clk(clk), .arstn(arstn),
        .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_aborted(cmd_aborted),
        .fifo_rd_dout(fifo_rd_dout), .fifo_rd_strb(fifo_rd_strb),
        .fifo_rd_ena(fifo_rd_ena), .fifo_rd_empty(fifo_rd_empty),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_last(wr_last), .wr_stall(wr_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference stream: every word pushed since reset; burst k owns words [d_base[k], d_base[k]+d_len[k]).
    word_t stream[$];
    int    avail = 0;
    int    rd_idx;
    int    d_len[64];
    int    d_base[64];
    bit    d_ab[64];
    int    n_issued = 0;
    int    next_base = 0;
    int    n_done;
    int    dcount;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural standard (non-FWFT) FIFO read port.
    always @(posedge clk or negedge arstn) begin
        int nidx;
        if (!arstn) begin
            rd_idx        <= 0;
            fifo_rd_dout  <= '0;
            fifo_rd_strb  <= '0;
            fifo_rd_empty <= 1'b1;
        end else begin
            nidx = rd_idx;
            if (fifo_rd_ena && rd_idx < avail) begin
                {fifo_rd_strb, fifo_rd_dout} <= stream[rd_idx];
                nidx = nidx + 1;
            end
            rd_idx        <= nidx;
            fifo_rd_empty <= (nidx >= avail);
        end
    end

    logic  prev_hold;
    word_t prev_word;

    always @(negedge clk) begin
        word_t exp_w;
        if (!arstn) begin
            n_done    = 0;
            dcount    = 0;
            prev_hold = 1'b0;
        end else begin
            if (fifo_rd_ena) chk("pop_while_empty", fifo_rd_empty, 1'b0);
            if (prev_hold && wr_valid) chk("stable_while_stalled", {wr_strb, wr_data}, prev_word);
            if (wr_valid && n_done < n_issued)
                chk("skid_depth_le2", ((rd_idx - d_base[n_done] - dcount) <= 2), 1'b1);
            if (wr_valid && wr_ready) begin
                if (n_done < n_issued) begin
                    exp_w = stream[d_base[n_done] + dcount];
                    chk("word", {wr_strb, wr_data}, exp_w);
                    chk("last", wr_last, (dcount == d_len[n_done] - 1));
                end else begin
                    chk("handshake_without_burst", 1'b1, 1'b0);
                end
                dcount++;
            end
            if (cmd_done) begin
                if (n_done < n_issued) begin
                    chk("aborted_flag", cmd_aborted, d_ab[n_done]);
                    chk("all_words_popped", rd_idx, d_base[n_done] + d_len[n_done]);
                    if (d_ab[n_done]) chk("aborted_short", (dcount < d_len[n_done]), 1'b1);
                    else              chk("delivered_all", dcount, d_len[n_done]);
                    n_done++;
                    dcount = 0;
                end else begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end
            end
            prev_hold = wr_valid & ~wr_ready;
            prev_word = {wr_strb, wr_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            stream.push_back(word_t'($urandom));
            avail++;
        end
    endtask

    task automatic start_burst(input int len, input bit legal);
        cmd_start = 1'b1;
        cmd_len   = len[8:0];
        if (legal) begin
            d_len[n_issued]  = len;
            d_base[n_issued] = next_base;
            d_ab[n_issued]   = 1'b0;
            n_issued++;
            next_base += len;
        end
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int s;
        int c;
        s = n_issued - 1;
        c = 0;
        while (n_done <= s && c < budget) begin
            tick();
            c++;
        end
        if (n_done <= s) chk("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic feed_handshakes(input int n);
        int hs;
        int c;
        hs = 0;
        c = 0;
        wr_ready = 1'b1;
        while (hs < n && c < 100) begin
            if (wr_valid) hs++;
            tick();
            c++;
        end
        wr_ready = 1'b0;
        if (hs < n) chk("handshake_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        logic [3:0] exp_t1 [6];
        exp_t1[0] = 4'b1000; exp_t1[1] = 4'b1100; exp_t1[2] = 4'b1100;
        exp_t1[3] = 4'b0100; exp_t1[4] = 4'b0110; exp_t1[5] = 4'b0001;

        #12;
        chk("reset_busy", cmd_busy, 1'b0);
        chk("reset_outs", {cmd_done, cmd_aborted, fifo_rd_ena, wr_valid, wr_last, wr_stall}, 6'b0);
        arstn = 1'b1;
        tick();

        // 1: preloaded burst of 4 with ready held high
        push_words(4);
        tick(); tick();
        wr_ready = 1'b1;
        start_burst(4, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk("t1_rdena_valid_last_done", {fifo_rd_ena, wr_valid, wr_last, cmd_done}, exp_t1[i]);
            tick();
        end
        chk("t1_idle", cmd_busy, 1'b0);

        // 2: ready toggling
        push_words(8);
        tick(); tick();
        wr_ready = 1'b0;
        start_burst(8, 1'b1);
        for (int c = 0; c < 200 && n_done < n_issued; c++) begin
            wr_ready = ~wr_ready;
            tick();
        end
        chk("t2_done", n_done, n_issued);

        // 3: underrun gaps
        push_words(2);
        tick(); tick();
        wr_ready = 1'b1;
        start_burst(6, 1'b1);
        repeat (8) tick();
        chk("t3_stall1", {wr_stall, wr_valid, cmd_busy}, 3'b101);
        push_words(3);
        repeat (10) tick();
        chk("t3_stall2", {wr_stall, wr_valid, cmd_busy}, 3'b101);
        push_words(1);
        wait_done(50);
        repeat (3) tick();
        chk("t3_single_done", n_done, n_issued);

        // 4: abort after 3 handshakes, then a short burst gets the following words
        push_words(12);
        tick(); tick();
        wr_ready = 1'b0;
        start_burst(10, 1'b1);
        feed_handshakes(3);
        cmd_abort = 1'b1;
        d_ab[n_issued - 1] = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("t4_valid_low", wr_valid, 1'b0);
        wait_done(50);
        wr_ready = 1'b1;
        start_burst(2, 1'b1);
        wait_done(50);

        // 5: asynchronous reset mid-burst
        push_words(5);
        tick(); tick();
        wr_ready = 1'b0;
        start_burst(5, 1'b1);
        feed_handshakes(2);
        #3;
        arstn = 1'b0;
        #1;
        chk("t5_async_outs", {cmd_busy, cmd_done, cmd_aborted, fifo_rd_ena, wr_valid, wr_last, wr_stall}, 7'b0);
        chk("t5_async_data", {wr_strb, wr_data}, 18'h0);
        stream.delete();
        avail = 0;
        n_issued = 0;
        next_base = 0;
        tick(); tick();
        arstn = 1'b1;
        repeat (5) tick();
        chk("t5_idle_no_done", {cmd_busy, n_done[7:0]}, 9'h0);

        // 6: illegal length and start-while-busy are ignored
        push_words(3);
        tick(); tick();
        start_burst(0, 1'b0);
        repeat (3) tick();
        chk("t6_len0_ignored", {cmd_busy, rd_idx[7:0]}, 9'h0);
        wr_ready = 1'b0;
        start_burst(3, 1'b1);
        tick();
        start_burst(5, 1'b0);
        wr_ready = 1'b1;
        wait_done(50);
        repeat (10) tick();
        chk("t6_single_done", {cmd_busy, n_done[7:0]}, 9'h1);

        // 7: abort coincident with the final handshake loses
        push_words(2);
        tick(); tick();
        start_burst(2, 1'b1);
        tick(); tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        wait_done(20);

        // Random bursts with random readiness, late pushes and occasional aborts
        for (int b = 0; b < 20; b++) begin
            int  len;
            int  pushed;
            int  k;
            int  c;
            int  s;
            bit  do_ab;
            len    = $urandom_range(1, 16);
            pushed = $urandom_range(0, len);
            do_ab  = ($urandom_range(0, 3) == 0);
            k      = $urandom_range(0, len + 3);
            push_words(pushed);
            tick(); tick();
            s = n_done;
            start_burst(len, 1'b1);
            c = 0;
            while (n_done == s && c < 500) begin
                if (do_ab && c == k && dcount < len) begin
                    wr_ready  = 1'b0;
                    cmd_abort = 1'b1;
                    d_ab[n_issued - 1] = 1'b1;
                end else begin
                    wr_ready  = $urandom_range(0, 1);
                    cmd_abort = 1'b0;
                end
                if (pushed < len && $urandom_range(0, 1) == 1) begin
                    push_words(1);
                    pushed++;
                end
                tick();
                c++;
            end
            cmd_abort = 1'b0;
            if (n_done == s) chk("rand_done_timeout", 1'b0, 1'b1);
        end
        chk("rand_all_done", n_done, n_issued);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
